btn_pulse_conditioner: RTL and testbench
========================================

Name: btn_pulse_conditioner

Overview:
Upstream input stage for game_logic. Takes the five raw, bouncing, asynchronous board push-buttons (U, D, L, R, C) and produces the clean single-cycle pulses game_logic consumes (BtnU_pulse etc.). Each button gets a 2-FF synchroniser and a stable-count debouncer. The four direction buttons also get press-and-hold auto-repeat, so the cursor can be walked across the board. The block runs on game_logic_clk (24.4 kHz).

Parameters:
DEBOUNCE_CYCLES, 488, consecutive stable cycles needed to accept a level change (~20 ms); must be >= 1.
REPEAT_EN, 1, 1 = auto-repeat enabled on U/D/L/R; C never repeats.
REPEAT_DELAY, 12207, cycles from first pulse to first repeat pulse (~0.5 s); must be >= 1.
REPEAT_PERIOD, 4883, cycles between subsequent repeat pulses (~0.2 s); must be >= 1.
CNT_W, 16, width of the debounce and repeat counters; all count parameters must be < 2^CNT_W.

Ports:
clk  in  1  game logic clock.
Reset  in  1  reset.
BtnU, BtnD, BtnL, BtnR, BtnC  in  1 each  raw asynchronous button levels, active-high.
BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse  out  1 each  one-cycle press/repeat pulse.
btn_state  out  5  debounced levels {U,D,L,R,C}, MSB = U.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- While Reset=1 at a clk edge, every register goes to 0: sync FFs, debounced levels, counters, FSMs, all outputs.
- Per-button pipeline: s1 <= raw; s2 <= s1. Only s2 feeds the debouncer.
- Debouncer: keeps a debounced level deb and counter dcnt.
  - s2 == deb: dcnt <= 0.
  - s2 != deb and dcnt == DEBOUNCE_CYCLES-1: deb <= s2, dcnt <= 0.
  - otherwise: dcnt <= dcnt+1.
  - Any return of s2 to deb before acceptance clears dcnt. Glitches shorter than DEBOUNCE_CYCLES cycles produce nothing.
- Latency: raw first sampled high at edge E0 (s1=1) gives deb rising at edge E0+1+DEBOUNCE_CYCLES. The press pulse is registered at that same edge, so it is high for exactly the cycle following E0+1+N (N = DEBOUNCE_CYCLES).
- btn_state equals the deb registers, with no extra delay.
- Direction-button FSM (U/D/L/R), with repeat counter rcnt:
  - IDLE: on deb 0->1, pulse=1, rcnt <= 0, go to DELAY.
  - DELAY: deb=0 -> IDLE. Else if rcnt == REPEAT_DELAY-1, pulse=1, rcnt <= 0, go to REPEAT. Else rcnt++.
  - REPEAT: deb=0 -> IDLE. Else if rcnt == REPEAT_PERIOD-1, pulse=1, rcnt <= 0. Else rcnt++.
  - Result: the first repeat comes REPEAT_DELAY cycles after the first pulse, then one every REPEAT_PERIOD cycles.
  - REPEAT_EN=0: the FSM never leaves DELAY toward REPEAT and no repeat pulses are issued (effectively behaves as IDLE/HELD).
- BtnC FSM: IDLE/HELD only. One pulse on deb 0->1, none while held, return to IDLE on deb=0.
- Release produces no pulse. deb falls N+1 cycles after raw falls (same latency rule as the press).
- Buttons are fully independent: no arbitration, and simultaneous pulses on several outputs are legal.
- Reset mid-hold: the state is cleared. If raw is still high after reset deasserts, s1 samples high at the first edge E0, and a fresh press pulse follows at E0+1+N (treated as a new press).
- Pulses are never wider than one cycle. Two consecutive pulses on one output are at least min(REPEAT_PERIOD, N) cycles apart.

Test Plan:
(Benches override N=4, REPEAT_DELAY=10, REPEAT_PERIOD=5 unless noted.)
- Reset: hold Reset 3 cycles with all buttons high -> all pulses and btn_state=0 during reset. First BtnU_pulse at edge E0+5 after release (E0 = first post-reset edge).
- Clean press, REPEAT_EN=0: BtnU high from E0 for 30 cycles -> BtnU_pulse high exactly 1 cycle after E0+5, btn_state=5'b10000 from E0+5, no further pulses. Release at E1 -> btn_state clears at E1+5, no pulse.
- Glitch/bounce: BtnL high 3 cycles -> no pulse, btn_state stays 0. Then the pattern 1,0,1,1,0 followed by steady 1 -> exactly one pulse, 5 cycles after the start of the steady 1.
- Auto-repeat: BtnR held 40 cycles from E0 -> BtnR_pulse at E0+5, +15, +20, +25, +30, +35, +40. Release -> pulses stop and the FSM returns to IDLE.
- Centre no-repeat plus simultaneity: BtnC and BtnD pressed on the same edge and held 40 cycles -> BtnC_pulse exactly once at E0+5. BtnD_pulse on the same cycle, then repeats as in the auto-repeat case.
- Reset mid-repeat: assert Reset while BtnR is in REPEAT -> next-cycle outputs 0. Button still held after release -> new first pulse 5 cycles after release, and the next repeat 10 cycles after that.

Source files
------------

// File: rtl/btn_pulse_conditioner_if.sv
// btn_pulse_conditioner_if: raw board buttons in, conditioned pulses and debounced levels out.
interface btn_pulse_conditioner_if;
    logic       BtnU, BtnD, BtnL, BtnR, BtnC;
    logic       BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse;
    logic [4:0] btn_state;

    modport master (
        output BtnU, BtnD, BtnL, BtnR, BtnC,
        input  BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse, btn_state
    );

    modport slave (
        input  BtnU, BtnD, BtnL, BtnR, BtnC,
        output BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse, btn_state
    );
endinterface

// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner: 2-FF sync, stable-count debounce and press/auto-repeat pulses
// for the five board buttons; bit order everywhere is {U,D,L,R,C}.
module btn_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 488,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 12207,
    parameter int REPEAT_PERIOD   = 4883,
    parameter int CNT_W           = 16
) (
    input logic                   clk,
    input logic                   Reset,
    btn_pulse_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [4:0] w_raw;
    logic [4:0] w_deb_v;
    logic [4:0] w_pls_v;

    assign w_raw = {bus.BtnU, bus.BtnD, bus.BtnL, bus.BtnR, bus.BtnC};

    genvar g;
    for (g = 0; g < 5; g++) begin : g_btn
        // C (bit 0) behaves as IDLE/HELD only
        localparam bit REP = REPEAT_EN && (g != 0);

        logic             r_s1, r_s2, r_deb, r_pulse;
        logic [CNT_W-1:0] r_dcnt, r_rcnt;
        state_t           r_st;
        logic             w_deb_nxt, w_pulse;
        logic [CNT_W-1:0] w_dcnt_nxt, w_rcnt_nxt;
        state_t           w_st_nxt;

        always_ff @(posedge clk) begin
            if (Reset) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_deb   <= 1'b0;
                r_dcnt  <= '0;
                r_st    <= IDLE;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_s1    <= w_raw[g];
                r_s2    <= r_s1;
                r_deb   <= w_deb_nxt;
                r_dcnt  <= w_dcnt_nxt;
                r_st    <= w_st_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_pulse <= w_pulse;
            end
        end

        always_comb begin
            w_deb_nxt  = r_deb;
            w_dcnt_nxt = r_dcnt + ONE;
            if (r_s2 == r_deb) begin
                w_dcnt_nxt = '0;
            end else if (r_dcnt == DB_LAST) begin
                w_deb_nxt  = r_s2;
                w_dcnt_nxt = '0;
            end
        end

        // The press pulse keys off the debouncer's next level so it lands on the acceptance edge
        always_comb begin
            w_st_nxt   = r_st;
            w_rcnt_nxt = r_rcnt;
            w_pulse    = 1'b0;
            if (!r_deb && w_deb_nxt) begin
                w_pulse    = 1'b1;
                w_rcnt_nxt = '0;
                w_st_nxt   = DELAY;
            end else if (!r_deb) begin
                w_rcnt_nxt = '0;
                w_st_nxt   = IDLE;
            end else if (r_st == DELAY && REP) begin
                w_pulse    = r_rcnt == RD_LAST;
                w_rcnt_nxt = w_pulse ? '0 : r_rcnt + ONE;
                w_st_nxt   = w_pulse ? REPEAT : DELAY;
            end else if (r_st == REPEAT) begin
                w_pulse    = r_rcnt == RP_LAST;
                w_rcnt_nxt = w_pulse ? '0 : r_rcnt + ONE;
            end
        end

        assign w_deb_v[g] = r_deb;
        assign w_pls_v[g] = r_pulse;
    end

    assign bus.btn_state  = w_deb_v;
    assign bus.BtnU_pulse = w_pls_v[4];
    assign bus.BtnD_pulse = w_pls_v[3];
    assign bus.BtnL_pulse = w_pls_v[2];
    assign bus.BtnR_pulse = w_pls_v[1];
    assign bus.BtnC_pulse = w_pls_v[0];
endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// tb_btn_pulse_conditioner: directed plus random button stimulus on a repeat and a no-repeat
// instance, checked against a window/age reference model.
module tb_btn_pulse_conditioner;
    localparam int N  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    btn_pulse_conditioner_if bus1();
    btn_pulse_conditioner_if bus0();

    btn_pulse_conditioner #(.DEBOUNCE_CYCLES(N), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD),
                            .REPEAT_PERIOD(RP), .CNT_W(16))
        dut1 (.clk(clk), .Reset(Reset), .bus(bus1));
    btn_pulse_conditioner #(.DEBOUNCE_CYCLES(N), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD),
                            .REPEAT_PERIOD(RP), .CNT_W(16))
        dut0 (.clk(clk), .Reset(Reset), .bus(bus0));

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // h[b][k] = raw level sampled k+1 edges ago
    logic [N:0] h [5];
    logic [4:0] m_deb = '0;
    logic [4:0] m_p1  = '0;
    logic [4:0] m_p0  = '0;
    int         rise [5];

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] raw);
        logic [N-1:0] win;
        logic         old;
        int           age;
        Reset = rst;
        {bus1.BtnU, bus1.BtnD, bus1.BtnL, bus1.BtnR, bus1.BtnC} = raw;
        {bus0.BtnU, bus0.BtnD, bus0.BtnL, bus0.BtnR, bus0.BtnC} = raw;
        @(posedge clk);
        t++;
        if (rst) begin
            for (int b = 0; b < 5; b++) h[b] = '0;
            m_deb = '0;
            m_p1  = '0;
            m_p0  = '0;
        end else begin
            for (int b = 0; b < 5; b++) begin
                old = m_deb[b];
                win = h[b][N:1];
                if (&win) m_deb[b] = 1'b1;
                else if (~|win) m_deb[b] = 1'b0;
                m_p1[b] = 1'b0;
                m_p0[b] = 1'b0;
                if (!old && m_deb[b]) begin
                    m_p1[b] = 1'b1;
                    m_p0[b] = 1'b1;
                    rise[b] = t;
                end else if (old) begin
                    age     = t - rise[b];
                    m_p1[b] = (b != 0) && age >= RD && (age - RD) % RP == 0;
                end
                h[b] = {h[b][N-1:0], raw[b]};
            end
        end
        @(negedge clk);
        chk("state_rep", bus1.btn_state, m_deb);
        chk("pulse_rep", {bus1.BtnU_pulse, bus1.BtnD_pulse, bus1.BtnL_pulse, bus1.BtnR_pulse,
                          bus1.BtnC_pulse}, m_p1);
        chk("state_norep", bus0.btn_state, m_deb);
        chk("pulse_norep", {bus0.BtnU_pulse, bus0.BtnD_pulse, bus0.BtnL_pulse, bus0.BtnR_pulse,
                            bus0.BtnC_pulse}, m_p0);
    endtask

    task automatic hold(input logic rst, input logic [4:0] raw, input int n);
        for (int i = 0; i < n; i++) step(rst, raw);
    endtask

    initial begin
        logic [4:0] cur;
        for (int b = 0; b < 5; b++) begin
            h[b]    = '0;
            rise[b] = 0;
        end
        hold(1'b1, 5'b11111, 3);
        hold(1'b0, 5'b11111, 30);
        hold(1'b0, 5'b00000, 10);
        hold(1'b0, 5'b10000, 30);
        hold(1'b0, 5'b00000, 10);
        hold(1'b0, 5'b00100, 3);
        hold(1'b0, 5'b00000, 6);
        step(1'b0, 5'b00100);
        step(1'b0, 5'b00000);
        step(1'b0, 5'b00100);
        step(1'b0, 5'b00100);
        step(1'b0, 5'b00000);
        hold(1'b0, 5'b00100, 12);
        hold(1'b0, 5'b00000, 10);
        hold(1'b0, 5'b00010, 40);
        hold(1'b0, 5'b00000, 15);
        hold(1'b0, 5'b01001, 40);
        hold(1'b0, 5'b00000, 15);
        hold(1'b0, 5'b00010, 30);
        hold(1'b1, 5'b00010, 2);
        hold(1'b0, 5'b00010, 25);
        hold(1'b0, 5'b00000, 10);
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(i < 1500 ? 5 : 39) == 0) cur[b] = ~cur[b];
            step($urandom_range(299) == 0, cur);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
